divmmc_spi: RTL

//  SPI master sequencing the SD card behind the DivMMC paging unit. Decodes Z80 I/O ports
//  E7h (card select) and EBh (data). Each EBh access runs one 8-bit mode-0 transfer. Sits

---
 rtl/divmmc_pkg.sv | 16 +
 rtl/spi_shifter.sv | 99 +++++++++
 rtl/divmmc_spi.sv | 122 ++++++++++++
 3 files changed

// File: rtl/divmmc_pkg.sv
// Shared DivMMC definitions: Z80 I/O port numbers, SPI sequencer state
// encoding and the default SCK half-period. The memory mapper imports the
// port constants from here as well.
package divmmc_pkg;

    localparam logic [7:0] PORT_CS   = 8'hE7;
    localparam logic [7:0] PORT_DATA = 8'hEB;

    localparam int unsigned DIV_DEFAULT = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_state_t;

endpackage

// File: rtl/spi_shifter.sv
// SPI mode-0 byte shifter: SCK divider, 8-bit shift register, bit counter
// and a one-tick done strobe. "result" carries the completed byte while
// done is high.
module spi_shifter
    import divmmc_pkg::*;
#(
    parameter int unsigned DIV = DIV_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic       start,
    input  logic [7:0] din,
    input  logic       miso,
    output logic       sck,
    output logic       mosi,
    output logic       busy,
    output logic       done,
    output logic [7:0] result
);

    localparam logic [3:0] DIV_LAST = 4'(DIV - 1);

    spi_state_t state, state_nx;
    logic [3:0] divcnt;
    logic [2:0] count;
    logic [7:0] sr;
    logic       latch;
    logic       load;
    logic       half;

    // state register
    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else if (ce)
            state <= state_nx;
    end

    // next state, strobes and outputs
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        half     = 1'b0;
        done     = 1'b0;
        busy     = 1'b0;
        mosi     = 1'b1;
        result   = {sr[6:0], latch};
        case (state)
            IDLE: begin
                load = ce & start;
                if (start)
                    state_nx = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                mosi = sr[7];
                half = ce & (divcnt == DIV_LAST);
                // final falling edge: sck is high and seven bits already shifted
                done = half & sck & (count == 3'd7);
                if (done)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // divider, sck and shift datapath
    always_ff @(posedge clock) begin
        if (reset) begin
            sck    <= 1'b0;
            divcnt <= '0;
            count  <= '0;
            sr     <= '1;
            latch  <= 1'b1;
        end else if (ce) begin
            if (load) begin
                sr     <= din;
                count  <= '0;
                divcnt <= '0;
                sck    <= 1'b0;
            end else if (state == SHIFT) begin
                if (half) begin
                    divcnt <= '0;
                    sck    <= ~sck;
                    if (!sck) begin
                        latch <= miso;
                    end else begin
                        sr    <= {sr[6:0], latch};
                        count <= count + 3'd1;
                    end
                end else begin
                    divcnt <= divcnt + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/divmmc_spi.sv
// DivMMC SD-card SPI master. Decodes port E7h (card select) and EBh (data);
// each EBh access runs one 8-bit mode-0 transfer.
// Optional macro DIVMMC_SPI_WAIT_EN: an EBh access arriving mid-byte is
// queued and the CPU is held on WAIT until it can start; without it such an
// access is dropped and cpuwait stays high.
module divmmc_spi
    import divmmc_pkg::*;
#(
    parameter int unsigned DIV = DIV_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic       enable,
    input  logic       iorq,
    input  logic       rd,
    input  logic       wr,
    input  logic [7:0] a,
    input  logic [7:0] d,
    output logic [7:0] q,
    output logic       qe,
    output logic       cpuwait,
    output logic       cs,
    output logic       sck,
    output logic       mosi,
    input  logic       miso
);

    logic       wr_e7, wr_eb, rd_eb;
    logic       access, prev, trig, trig_eb;
    logic       busy, done, start;
    logic [7:0] din, result;

    // port decode and access edge
    always_comb begin
        wr_e7   = enable & ~iorq & ~wr & (a == PORT_CS);
        wr_eb   = enable & ~iorq & ~wr & (a == PORT_DATA);
        rd_eb   = enable & ~iorq & ~rd & (a == PORT_DATA);
        qe      = ~reset & rd_eb;
        access  = wr_e7 | wr_eb | rd_eb;
        trig    = ce & access & ~prev;
        trig_eb = trig & (wr_eb | rd_eb);
    end

    // previous-access register, one trigger per bus cycle
    always_ff @(posedge clock) begin
        if (reset)
            prev <= 1'b0;
        else if (ce)
            prev <= access;
    end

    // chip select and received-byte register
    always_ff @(posedge clock) begin
        if (reset) begin
            cs <= 1'b1;
            q  <= 8'hFF;
        end else if (ce) begin
            if (trig & wr_e7)
                cs <= d[0];
            if (done)
                q <= result;
        end
    end

`ifdef DIVMMC_SPI_WAIT_EN
    logic       pending, pend_rd;
    logic [7:0] pend_d;

    // single pending slot for an access that lands while a byte is shifting
    always_ff @(posedge clock) begin
        if (reset) begin
            pending <= 1'b0;
            pend_rd <= 1'b0;
            pend_d  <= '0;
        end else if (ce) begin
            if (pending && !busy) begin
                pending <= 1'b0;
            end else if (trig_eb && busy && !pending) begin
                pending <= 1'b1;
                pend_rd <= rd_eb;
                pend_d  <= d;
            end
        end
    end

    // start source select: a pending access wins on the first idle tick
    always_comb begin
        start   = trig_eb & ~busy;
        din     = rd_eb ? 8'hFF : d;
        cpuwait = ~pending;
        if (pending) begin
            start = ~busy;
            din   = pend_rd ? 8'hFF : pend_d;
        end
    end
`else
    // start only from idle; accesses during a byte are dropped
    always_comb begin
        start   = trig_eb & ~busy;
        din     = rd_eb ? 8'hFF : d;
        cpuwait = 1'b1;
    end
`endif

    spi_shifter #(
        .DIV(DIV)
    ) u_shifter (
        .clock  (clock),
        .reset  (reset),
        .ce     (ce),
        .start  (start),
        .din    (din),
        .miso   (miso),
        .sck    (sck),
        .mosi   (mosi),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

endmodule
